// File: rtl/tlc_conflict_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlc_conflict_monitor : lamp-code safety checker between TLC FSM & drivers |
// | Optional TLC_MON_FLASH_EN flashes the all-red during FAULT.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tlc_conflict_monitor #(
  parameter int MIN_YELLOW_CYC = 1,
  parameter int MAX_PHASE_CYC  = 8,
  parameter int FLASH_HALF     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] EW,
  input  logic [2:0] NS,
  input  logic       fault_clr,
  output logic [2:0] ew_lamp,
  output logic [2:0] ns_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int CW = $clog2(MAX_PHASE_CYC + 1);
  localparam logic [CW-1:0] c_MIN_Y   = CW'(MIN_YELLOW_CYC);
  localparam logic [CW-1:0] c_MAX_RUN = CW'(MAX_PHASE_CYC);
  localparam logic [CW-1:0] c_SAT     = {CW{1'b1}};
  localparam logic [CW-1:0] c_ONE     = CW'(1);
  localparam logic [2:0]    c_GRN     = 3'b100;
  localparam logic [2:0]    c_YEL     = 3'b010;
  localparam logic [2:0]    c_RED     = 3'b001;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  generate
    if (MIN_YELLOW_CYC < 1 || MAX_PHASE_CYC < 2 || FLASH_HALF < 1) begin : g_bad_params
      $error("tlc_conflict_monitor: invalid parameter values");
    end
  endgenerate

  function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] v);
    return (v == c_SAT) ? v : v + c_ONE;
  endfunction

  function automatic logic f_onehot(input logic [2:0] v);
    return (v == c_GRN) || (v == c_YEL) || (v == c_RED);
  endfunction

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_ew_lamp, w_ew_lamp_nxt;
  logic [2:0]      r_ns_lamp, w_ns_lamp_nxt;
  logic            r_fault, w_fault_nxt;
  logic [2:0]      r_code, w_code_nxt;
  logic [2:0]      r_prev_ew, w_prev_ew_nxt;
  logic [2:0]      r_prev_ns, w_prev_ns_nxt;
  logic            r_prev_valid, w_prev_valid_nxt;
  logic [CW-1:0]   r_run, w_run_nxt;
  logic [CW-1:0]   r_ycnt_ew, w_ycnt_ew_nxt;
  logic [CW-1:0]   r_ycnt_ns, w_ycnt_ns_nxt;
`ifdef TLC_MON_FLASH_EN
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] c_FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] c_FLASH_HALF = FW'(FLASH_HALF);
  localparam logic [FW-1:0] c_FLASH_ONE  = FW'(1);
  logic [FW-1:0]   r_flash, w_flash_nxt;
`endif

  logic          w_c1, w_c2, w_c3, w_c4, w_c5, w_same, w_viol;
  logic [2:0]    w_code;
  logic [CW-1:0] w_run_inc;

  // Checks compare the live sample against the last accepted sample.
  always_comb begin
    w_same    = r_prev_valid && (EW == r_prev_ew) && (NS == r_prev_ns);
    w_run_inc = f_sat_inc(r_run);
    w_c1 = !f_onehot(EW) || !f_onehot(NS);
    w_c2 = (EW != c_RED) && (NS != c_RED);
    w_c3 = r_prev_valid &&
           ((r_prev_ew == c_GRN && EW == c_RED) || (r_prev_ew == c_RED && EW == c_YEL) ||
            (r_prev_ns == c_GRN && NS == c_RED) || (r_prev_ns == c_RED && NS == c_YEL));
    w_c4 = r_prev_valid &&
           ((r_prev_ew == c_YEL && EW == c_RED && r_ycnt_ew < c_MIN_Y) ||
            (r_prev_ns == c_YEL && NS == c_RED && r_ycnt_ns < c_MIN_Y));
    w_c5 = w_same && (w_run_inc >= c_MAX_RUN);
    if (w_c1)      w_code = 3'd1;
    else if (w_c2) w_code = 3'd2;
    else if (w_c3) w_code = 3'd3;
    else if (w_c4) w_code = 3'd4;
    else if (w_c5) w_code = 3'd5;
    else           w_code = 3'd0;
    w_viol = (w_code != 3'd0);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ew_lamp_nxt    = r_ew_lamp;
    w_ns_lamp_nxt    = r_ns_lamp;
    w_fault_nxt      = r_fault;
    w_code_nxt       = r_code;
    w_prev_ew_nxt    = r_prev_ew;
    w_prev_ns_nxt    = r_prev_ns;
    w_prev_valid_nxt = r_prev_valid;
    w_run_nxt        = r_run;
    w_ycnt_ew_nxt    = r_ycnt_ew;
    w_ycnt_ns_nxt    = r_ycnt_ns;
`ifdef TLC_MON_FLASH_EN
    w_flash_nxt      = r_flash;
`endif
    case (r_state)
      ST_MONITOR: begin
        if (w_viol) begin
          w_state_nxt   = ST_FAULT;
          w_fault_nxt   = 1'b1;
          w_code_nxt    = w_code;
          w_ew_lamp_nxt = c_RED;
          w_ns_lamp_nxt = c_RED;
`ifdef TLC_MON_FLASH_EN
          w_flash_nxt   = '0;
`endif
        end else begin
          w_ew_lamp_nxt = EW;
          w_ns_lamp_nxt = NS;
          w_prev_ew_nxt = EW;
          w_prev_ns_nxt = NS;
          w_run_nxt     = w_same ? w_run_inc : c_ONE;
          w_ycnt_ew_nxt = (EW == c_YEL) ? f_sat_inc(r_ycnt_ew) : '0;
          w_ycnt_ns_nxt = (NS == c_YEL) ? f_sat_inc(r_ycnt_ns) : '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_state_nxt      = ST_RECOVER;
          w_fault_nxt      = 1'b0;
          w_code_nxt       = 3'd0;
          w_ew_lamp_nxt    = c_RED;
          w_ns_lamp_nxt    = c_RED;
          w_prev_valid_nxt = 1'b0;
          w_run_nxt        = '0;
          w_ycnt_ew_nxt    = '0;
          w_ycnt_ns_nxt    = '0;
`ifdef TLC_MON_FLASH_EN
          w_flash_nxt      = '0;
`endif
        end else begin
`ifdef TLC_MON_FLASH_EN
          // First half-period red, second half dark.
          w_flash_nxt   = (r_flash == c_FLASH_LAST) ? '0 : r_flash + c_FLASH_ONE;
          w_ew_lamp_nxt = (w_flash_nxt < c_FLASH_HALF) ? c_RED : 3'b000;
          w_ns_lamp_nxt = (w_flash_nxt < c_FLASH_HALF) ? c_RED : 3'b000;
`else
          w_ew_lamp_nxt = c_RED;
          w_ns_lamp_nxt = c_RED;
`endif
        end
      end
      default: begin
        w_ew_lamp_nxt = c_RED;
        w_ns_lamp_nxt = c_RED;
        if (EW == c_GRN && NS == c_RED) begin
          w_state_nxt      = ST_MONITOR;
          w_ew_lamp_nxt    = EW;
          w_ns_lamp_nxt    = NS;
          w_prev_ew_nxt    = EW;
          w_prev_ns_nxt    = NS;
          w_prev_valid_nxt = 1'b1;
          w_run_nxt        = c_ONE;
          w_ycnt_ew_nxt    = '0;
          w_ycnt_ns_nxt    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RECOVER;
      r_ew_lamp    <= c_RED;
      r_ns_lamp    <= c_RED;
      r_fault      <= 1'b0;
      r_code       <= 3'd0;
      r_prev_ew    <= 3'd0;
      r_prev_ns    <= 3'd0;
      r_prev_valid <= 1'b0;
      r_run        <= '0;
      r_ycnt_ew    <= '0;
      r_ycnt_ns    <= '0;
`ifdef TLC_MON_FLASH_EN
      r_flash      <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ew_lamp    <= w_ew_lamp_nxt;
      r_ns_lamp    <= w_ns_lamp_nxt;
      r_fault      <= w_fault_nxt;
      r_code       <= w_code_nxt;
      r_prev_ew    <= w_prev_ew_nxt;
      r_prev_ns    <= w_prev_ns_nxt;
      r_prev_valid <= w_prev_valid_nxt;
      r_run        <= w_run_nxt;
      r_ycnt_ew    <= w_ycnt_ew_nxt;
      r_ycnt_ns    <= w_ycnt_ns_nxt;
`ifdef TLC_MON_FLASH_EN
      r_flash      <= w_flash_nxt;
`endif
    end
  end

  assign ew_lamp    = r_ew_lamp;
  assign ns_lamp    = r_ns_lamp;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_tlc_conflict_monitor.sv
`default_nettype none
// Bench for tlc_conflict_monitor: directed table, hand sequences and a
// randomized run against a history-based reference model (two instances).
module tb_tlc_conflict_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] EW, NS;
  logic       fault_clr;
  logic [2:0] a_ew, a_ns, a_code, b_ew, b_ns, b_code;
  logic       a_fault, b_fault;

  int checks = 0;
  int errors = 0;

  tlc_conflict_monitor #(.MIN_YELLOW_CYC(1), .MAX_PHASE_CYC(8), .FLASH_HALF(4)) dut (
    .clk(clk), .rst(rst), .EW(EW), .NS(NS), .fault_clr(fault_clr),
    .ew_lamp(a_ew), .ns_lamp(a_ns), .fault(a_fault), .fault_code(a_code));

  tlc_conflict_monitor #(.MIN_YELLOW_CYC(2), .MAX_PHASE_CYC(8), .FLASH_HALF(4)) dut2 (
    .clk(clk), .rst(rst), .EW(EW), .NS(NS), .fault_clr(fault_clr),
    .ew_lamp(b_ew), .ns_lamp(b_ns), .fault(b_fault), .fault_code(b_code));

  always #5 clk = ~clk;

  // Reference model: mode 0 monitor, 1 fault, 2 recover; history of accepted samples.
  int         m_mode [2];
  logic [5:0] m_hist [2][16];
  int         m_hlen [2];
  logic [2:0] m_ew [2], m_ns [2], m_fc [2];
  logic       m_fault [2];
  int         m_fcyc [2];
  int         m_miny [2] = '{1, 2};

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = 2; m_hlen[m] = 0; m_ew[m] = 3'b001; m_ns[m] = 3'b001;
      m_fault[m] = 1'b0; m_fc[m] = 3'd0; m_fcyc[m] = 0;
    end
  endtask

  task automatic m_step(input int m, input logic [2:0] ew, input logic [2:0] ns, input logic clr);
    int code, run, yre, yrn;
    logic [5:0] last;
    logic [2:0] pe, pn;
    if (m_mode[m] == 2) begin
      if (ew == 3'b100 && ns == 3'b001) begin
        m_mode[m] = 0; m_hist[m][0] = {ew, ns}; m_hlen[m] = 1;
        m_ew[m] = ew; m_ns[m] = ns;
      end else begin
        m_ew[m] = 3'b001; m_ns[m] = 3'b001;
      end
    end else if (m_mode[m] == 0) begin
      last = m_hist[m][m_hlen[m]-1];
      pe = last[5:3]; pn = last[2:0];
      run = 0; yre = 0; yrn = 0;
      for (int k = m_hlen[m] - 1; k >= 0; k--) begin
        if (m_hist[m][k] == last) run++; else break;
      end
      for (int k = m_hlen[m] - 1; k >= 0; k--) begin
        if (m_hist[m][k][5:3] == 3'b010) yre++; else break;
      end
      for (int k = m_hlen[m] - 1; k >= 0; k--) begin
        if (m_hist[m][k][2:0] == 3'b010) yrn++; else break;
      end
      code = 0;
      if ($countones(ew) != 1 || $countones(ns) != 1) code = 1;
      else if (ew != 3'b001 && ns != 3'b001) code = 2;
      else if ((pe == 3'b100 && ew == 3'b001) || (pe == 3'b001 && ew == 3'b010) ||
               (pn == 3'b100 && ns == 3'b001) || (pn == 3'b001 && ns == 3'b010)) code = 3;
      else if ((pe == 3'b010 && ew == 3'b001 && yre < m_miny[m]) ||
               (pn == 3'b010 && ns == 3'b001 && yrn < m_miny[m])) code = 4;
      else if ({ew, ns} == last && run + 1 >= 8) code = 5;
      if (code != 0) begin
        m_mode[m] = 1; m_fault[m] = 1'b1; m_fc[m] = 3'(code); m_fcyc[m] = 0;
        m_ew[m] = 3'b001; m_ns[m] = 3'b001;
      end else begin
        if (m_hlen[m] == 16) begin
          for (int k = 0; k < 15; k++) m_hist[m][k] = m_hist[m][k+1];
          m_hist[m][15] = {ew, ns};
        end else begin
          m_hist[m][m_hlen[m]] = {ew, ns};
          m_hlen[m]++;
        end
        m_ew[m] = ew; m_ns[m] = ns;
      end
    end else begin
      if (clr) begin
        m_mode[m] = 2; m_fault[m] = 1'b0; m_fc[m] = 3'd0;
        m_ew[m] = 3'b001; m_ns[m] = 3'b001;
      end else begin
        m_fcyc[m]++;
`ifdef TLC_MON_FLASH_EN
        m_ew[m] = ((m_fcyc[m] / 4) % 2 == 0) ? 3'b001 : 3'b000;
`else
        m_ew[m] = 3'b001;
`endif
        m_ns[m] = m_ew[m];
      end
    end
  endtask

  function automatic logic [9:0] m_exp(input int m);
    return {m_ew[m], m_ns[m], m_fault[m], m_fc[m]};
  endfunction

  function automatic logic [5:0] legal(input int i);
    case (i % 4)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      2:       return 6'b001_100;
      default: return 6'b001_010;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ew/ns/fault/code=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [2:0] ew, input logic [2:0] ns, input logic clr);
    EW = ew; NS = ns; fault_clr = clr;
    @(posedge clk);
    m_step(0, ew, ns, clr);
    m_step(1, ew, ns, clr);
    #1;
  endtask

  task automatic do_reset();
    EW = 3'b001; NS = 3'b001; fault_clr = 1'b0;
    @(negedge clk); rst = 1'b0; m_reset();
    @(negedge clk); rst = 1'b1;
  endtask

  typedef struct {
    logic [2:0] ew, ns;
    logic       clr;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl [21];

  initial begin
    logic [5:0] s;
    int idx, r;
    tbl[0]  = '{3'b100, 3'b001, 1'b0, 10'b100_001_0_000};
    tbl[1]  = '{3'b100, 3'b100, 1'b0, 10'b001_001_1_010};
    tbl[2]  = '{3'b100, 3'b001, 1'b0, 10'b001_001_1_010};
    tbl[3]  = '{3'b010, 3'b001, 1'b1, 10'b001_001_0_000};
    tbl[4]  = '{3'b010, 3'b001, 1'b0, 10'b001_001_0_000};
    tbl[5]  = '{3'b100, 3'b001, 1'b0, 10'b100_001_0_000};
    tbl[6]  = '{3'b001, 3'b001, 1'b0, 10'b001_001_1_011};
    tbl[7]  = '{3'b001, 3'b001, 1'b1, 10'b001_001_0_000};
    tbl[8]  = '{3'b100, 3'b001, 1'b0, 10'b100_001_0_000};
    tbl[9]  = '{3'b100, 3'b001, 1'b1, 10'b100_001_0_000};
    tbl[10] = '{3'b010, 3'b001, 1'b0, 10'b010_001_0_000};
    tbl[11] = '{3'b010, 3'b001, 1'b0, 10'b010_001_0_000};
    tbl[12] = '{3'b001, 3'b100, 1'b0, 10'b001_100_0_000};
    tbl[13] = '{3'b011, 3'b100, 1'b0, 10'b001_001_1_001};
    tbl[14] = '{3'b001, 3'b100, 1'b1, 10'b001_001_0_000};
    tbl[15] = '{3'b100, 3'b001, 1'b0, 10'b100_001_0_000};
    tbl[16] = '{3'b010, 3'b010, 1'b1, 10'b001_001_1_010};
    tbl[17] = '{3'b111, 3'b111, 1'b1, 10'b001_001_0_000};
    tbl[18] = '{3'b100, 3'b001, 1'b0, 10'b100_001_0_000};
    tbl[19] = '{3'b001, 3'b100, 1'b0, 10'b001_001_1_011};
    tbl[20] = '{3'b001, 3'b001, 1'b1, 10'b001_001_0_000};

    rst = 1'b0; EW = 3'b001; NS = 3'b001; fault_clr = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_0_000);
    chk("reset_b", {b_ew, b_ns, b_fault, b_code}, 10'b001_001_0_000);
    @(negedge clk); rst = 1'b1;

    tick(3'b010, 3'b001, 1'b0);
    chk("recover_wait", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_0_000);
    for (int i = 0; i < 20; i++) begin
      s = legal(i);
      tick(s[5:3], s[2:0], 1'b0);
      chk("normal_seq", {a_ew, a_ns, a_fault, a_code}, {s, 4'b0000});
    end

    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].ew, tbl[i].ns, tbl[i].clr);
      chk($sformatf("table[%0d]", i), {a_ew, a_ns, a_fault, a_code}, tbl[i].exp);
    end

    // Stuck phase: eighth identical sample faults.
    for (int i = 1; i <= 8; i++) begin
      tick(3'b100, 3'b001, 1'b0);
      chk($sformatf("stuck_%0d", i), {a_ew, a_ns, a_fault, a_code},
          (i < 8) ? 10'b100_001_0_000 : 10'b001_001_1_101);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(3'b100, 3'b001, 1'b0);
`ifdef TLC_MON_FLASH_EN
      s = (i < 4 || i == 8) ? 6'b001_001 : 6'b000_000;
`else
      s = 6'b001_001;
`endif
      chk($sformatf("fault_lamps_%0d", i), {a_ew, a_ns, a_fault, a_code}, {s, 4'b1101});
    end
    tick(3'b010, 3'b001, 1'b1);
    chk("clr_to_recover", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_0_000);
    tick(3'b100, 3'b001, 1'b0);
    chk("recover_to_mon", {a_ew, a_ns, a_fault, a_code}, 10'b100_001_0_000);

    // Short yellow with MIN_YELLOW_CYC=2 on the second instance.
    do_reset();
    tick(3'b100, 3'b001, 1'b0);
    tick(3'b010, 3'b001, 1'b0);
    chk("yel1_a", {a_ew, a_ns, a_fault, a_code}, 10'b010_001_0_000);
    chk("yel1_b", {b_ew, b_ns, b_fault, b_code}, 10'b010_001_0_000);
    tick(3'b001, 3'b100, 1'b0);
    chk("short_yel_a", {a_ew, a_ns, a_fault, a_code}, 10'b001_100_0_000);
    chk("short_yel_b", {b_ew, b_ns, b_fault, b_code}, 10'b001_001_1_100);

    // Asynchronous reset in the middle of FAULT.
    tick(3'b100, 3'b100, 1'b0);
    chk("pre_rst_fault", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_1_010);
    #2; rst = 1'b0; m_reset();
    #1;
    chk("async_rst_a", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_0_000);
    chk("async_rst_b", {b_ew, b_ns, b_fault, b_code}, 10'b001_001_0_000);
    @(negedge clk); rst = 1'b1;
    tick(3'b010, 3'b001, 1'b0);
    chk("post_rst_wait", {a_ew, a_ns, a_fault, a_code}, 10'b001_001_0_000);
    tick(3'b100, 3'b001, 1'b0);
    chk("post_rst_mon", {a_ew, a_ns, a_fault, a_code}, 10'b100_001_0_000);

    // Randomized mostly-legal controller with occasional corruption and clears.
    do_reset();
    idx = 0;
    for (int c = 0; c < 500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 60) idx++;
      else if (r < 70) idx += 2;
      s = legal(idx);
      if (r >= 92) s = 6'($urandom_range(0, 63));
      tick(s[5:3], s[2:0], ($urandom_range(0, 7) == 0));
      chk("rand_a", {a_ew, a_ns, a_fault, a_code}, m_exp(0));
      chk("rand_b", {b_ew, b_ns, b_fault, b_code}, m_exp(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
Safety stage directly downstream of the traffic-light controller FSM. Samples the controller's EW/NS lamp codes every clock and checks them for illegal encodings, conflicting greens, illegal phase sequences, short yellows and stuck phases. Healthy codes pass to the lamp drivers with one cycle of latency. On any violation it latches a fault, drives all-red (optionally flashing), and waits for an operator clear followed by a clean cycle start before passing codes through again.

Parameters:
MIN_YELLOW_CYC, 1, minimum consecutive yellow samples required before that approach returns to red.
MAX_PHASE_CYC, 8, maximum consecutive identical {EW,NS} samples before a stuck fault is raised.
FLASH_HALF, 4, half-period of the fault flash in cycles; used only with TLC_MON_FLASH_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
EW  input  3  controller East-West code: 100 green, 010 yellow, 001 red.
NS  input  3  controller North-South code, same encoding.
fault_clr  input  1  single-cycle operator clear; honoured only in FAULT.
ew_lamp  output  3  registered East-West lamp drive.
ns_lamp  output  3  registered North-South lamp drive.
fault  output  1  high while in FAULT.
fault_code  output  3  latched cause: 0 none, 1 bad encoding, 2 conflict, 3 bad sequence, 4 short yellow, 5 stuck.

Behaviour:
- All outputs are registered. While rst is low: state=RECOVER, ew_lamp=001, ns_lamp=001, fault=0, fault_code=0, history and counters cleared, prev_valid=0.
- States: MONITOR, FAULT, RECOVER.
- MONITOR:
  - ew_lamp/ns_lamp take the EW/NS values sampled one edge earlier, so latency is 1 cycle.
  - All checks run combinationally on the current sample against the registered previous sample. When checks flag, the lowest code wins.
  - Code 1: EW or NS is not one-hot.
  - Code 2: EW and NS are both non-red.
  - Code 3 (only when prev_valid): an approach goes green->red or red->yellow.
  - Code 4 (only when prev_valid): an approach goes yellow->red with its yellow run length < MIN_YELLOW_CYC.
  - Code 5: the sample equals the previous one and the run length reaches MAX_PHASE_CYC.
  - On a violation, at the next edge: state=FAULT, fault=1, fault_code=cause, lamps=001/001. The offending code never reaches the lamps.
- Counters:
  - Run-length and per-approach yellow counters are $clog2(MAX_PHASE_CYC+1) bits and saturate; they never wrap.
  - The run-length counter resets to 1 on any change of {EW,NS}.
  - Each yellow counter resets to 0 when its approach is not yellow.
- FAULT:
  - fault_code holds the first cause; later violations are ignored.
  - Inputs are not passed through.
  - Lamps are red per the optional feature.
  - fault_clr=1 -> RECOVER next edge, with fault=0 and fault_code=0 on that edge. fault_clr wins over any simultaneous violation.
- RECOVER:
  - Lamps solid 001/001 and no checks.
  - When the sample is EW=100 and NS=001 -> MONITOR next edge. Lamps show 100/001 on that edge, prev_valid=1, and the run length is 1.
  - Any other sample stays in RECOVER.
- fault_clr in MONITOR or RECOVER has no effect.
- Reset asserted mid-operation (any state) forces the reset values immediately, independent of clk.
- A controller cycling 100/001 -> 010/001 -> 001/100 -> 001/010 with 1-cycle phases and default parameters never faults.

Optional Feature:
TLC_MON_FLASH_EN
- Defined: in FAULT, a flash counter (reset to 0 on FAULT entry) toggles the lamps every FLASH_HALF cycles. Lamps are 001/001 for the first FLASH_HALF cycles, then 000/000 for FLASH_HALF, and repeat. The flash counter is cleared on exit.
- Undefined: lamps are solid 001/001 throughout FAULT, and no flash counter is built.

Test Plan:
- Reset release, normal controller sequence for 20 cycles -> lamps follow EW/NS delayed 1 cycle after the first 100/001 is seen; fault=0 throughout.
- In MONITOR force EW=100, NS=100 -> next edge fault=1, fault_code=2, lamps 001/001.
- Drive 100/001 then 001/001 (yellow skipped) -> fault_code=3. With MIN_YELLOW_CYC=2 and a normal 1-cycle yellow -> fault_code=4.
- Hold 100/001 for 8 cycles (MAX_PHASE_CYC=8) -> fault on the 8th sample, fault_code=5. With TLC_MON_FLASH_EN, lamps show 4 cycles 001/001 then 4 cycles 000/000.
- Raise fault_clr in FAULT while EW=010 -> RECOVER, lamps 001/001. When 100/001 arrives -> MONITOR with lamps 100/001 next edge. fault_clr while in MONITOR has no effect.
- Assert rst mid-FAULT -> outputs immediately 001/001, fault=0, fault_code=0; after release the block waits in RECOVER.
